mc_txn_scheduler: RTL and testbench

Memory-controller-side transaction scheduler. Takes one decoded peripheral request per transaction (from the peripheral-to-MC decoder), screens it for errors, runs the access on the memory port, and sequences the 96-bit response message (WAIT / READY / RETRANSMIT) back to the UART transmitter. It owns the MC side of the peripheral protocol: retry accounting, memory handshake and transmit handshake.

---
 rtl/mc_msg_pkg.sv | 32 +++
 rtl/mc_msg_builder.sv | 15 +
 rtl/mc_txn_scheduler.sv | 226 ++++++++++++++++++++++
 tb/tb_mc_txn_scheduler.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_msg_pkg.sv
// Shared constants, frame field widths and FSM state type for the MC transaction scheduler.
package mc_msg_pkg;

  localparam int START_W = 8;
  localparam int HDR_W   = 16;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 24;
  localparam int ERR_W   = 8;
  localparam int END_W   = 8;
  localparam int MSG_W   = START_W + HDR_W + DATA_W + ADDR_W + ERR_W + END_W;

  localparam logic [START_W-1:0] MSG_START = 8'h0F;
  localparam logic [END_W-1:0]   MSG_END   = 8'hF0;

  localparam logic [HDR_W-1:0] HDR_READ  = 16'h0001;
  localparam logic [HDR_W-1:0] HDR_WRITE = 16'h0002;
  localparam logic [HDR_W-1:0] HDR_WAIT  = 16'hFFF1;
  localparam logic [HDR_W-1:0] HDR_READY = 16'hFFF2;
  localparam logic [HDR_W-1:0] HDR_RETX  = 16'hFFF3;

  localparam logic [ERR_W-1:0] ERR_NONE = 8'h00;
  localparam logic [ERR_W-1:0] ERR_SET  = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    MEM,
    TX_WAIT,
    TX
  } state_t;

endpackage

// File: rtl/mc_msg_builder.sv
// Packs header, data, address and error byte into the 96-bit response frame.
// Purely combinational; the scheduler registers the result.
module mc_msg_builder
  import mc_msg_pkg::*;
(
  input  logic [HDR_W-1:0]  hdr,
  input  logic [DATA_W-1:0] data,
  input  logic [ADDR_W-1:0] addr,
  input  logic [ERR_W-1:0]  err,
  output logic [MSG_W-1:0]  msg
);

  assign msg = {MSG_START, hdr, data, addr, err, MSG_END};

endmodule

// File: rtl/mc_txn_scheduler.sv
// Screens decoded requests, runs the memory access and sequences response frames.
// Define MC_WAIT_MSG_EN to add one WAIT frame after WAIT_CYCLES stalled memory cycles.
module mc_txn_scheduler
  import mc_msg_pkg::*;
#(
  parameter int MAX_RETRY = 3
`ifdef MC_WAIT_MSG_EN
  ,
  parameter int WAIT_CYCLES = 8
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iReqValid,
  input  logic              iRead,
  input  logic              iWrite,
  input  logic [ADDR_W-1:0] iAddr,
  input  logic [DATA_W-1:0] iData,
  input  logic              iError,
  output logic              oBusy,
  output logic              oMemReq,
  output logic              oMemWe,
  output logic [ADDR_W-1:0] oMemAddr,
  output logic [DATA_W-1:0] oMemWData,
  input  logic              iMemAck,
  input  logic [DATA_W-1:0] iMemRData,
  output logic              oTransmit,
  output logic [MSG_W-1:0]  oTxMsg,
  input  logic              iTxDone,
  output logic              oDropped
);

  localparam logic [3:0] RETRY_LIM = 4'(MAX_RETRY);

  state_t state, state_n;

  logic              rd_q;
  logic              wr_q;
  logic              err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [3:0]        retry_cnt;
  logic [MSG_W-1:0]  tx_msg;
  logic [MSG_W-1:0]  msg_n;
  logic              transmit;
  logic              dropped;

  logic              load;
  logic              inc_retry;
  logic              clr_retry;
  logic              drop;
  logic              tx_load;
  logic              bad;
  logic [HDR_W-1:0]  hdr_n;
  logic [DATA_W-1:0] data_n;
  logic [ERR_W-1:0]  err_n;

`ifdef MC_WAIT_MSG_EN
  localparam logic [15:0] STALL_LIM = 16'(WAIT_CYCLES);

  logic [15:0]       stall_cnt;
  logic              wait_sent;
  logic              ack_seen;
  logic [DATA_W-1:0] rdata_q;
  logic              stall_inc;
  logic              wait_set;
  logic              cap;
`endif

  assign bad = err_q | (rd_q == wr_q);

  mc_msg_builder u_builder (
    .hdr  (hdr_n),
    .data (data_n),
    .addr (addr_q),
    .err  (err_n),
    .msg  (msg_n)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    load      = 1'b0;
    inc_retry = 1'b0;
    clr_retry = 1'b0;
    drop      = 1'b0;
    tx_load   = 1'b0;
    hdr_n     = HDR_READY;
    data_n    = '0;
    err_n     = ERR_NONE;
`ifdef MC_WAIT_MSG_EN
    stall_inc = 1'b0;
    wait_set  = 1'b0;
    cap       = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (iReqValid) begin
          load    = 1'b1;
          state_n = CHECK;
        end
      end
      CHECK: begin
        if (!bad) begin
          clr_retry = 1'b1;
          state_n   = MEM;
        end else if (retry_cnt < RETRY_LIM) begin
          inc_retry = 1'b1;
          tx_load   = 1'b1;
          hdr_n     = HDR_RETX;
          err_n     = ERR_SET;
          state_n   = TX;
        end else begin
          drop      = 1'b1;
          clr_retry = 1'b1;
          state_n   = IDLE;
        end
      end
      MEM: begin
        if (iMemAck) begin
          tx_load = 1'b1;
          data_n  = wr_q ? data_q : iMemRData;
          state_n = TX;
        end
`ifdef MC_WAIT_MSG_EN
        // an ack on the threshold cycle takes the branch above, so no WAIT
        else if (!wait_sent) begin
          stall_inc = 1'b1;
          if (stall_cnt + 16'd1 == STALL_LIM) begin
            wait_set = 1'b1;
            tx_load  = 1'b1;
            hdr_n    = HDR_WAIT;
            state_n  = TX_WAIT;
          end
        end
`endif
      end
      TX_WAIT: begin
`ifdef MC_WAIT_MSG_EN
        if (iMemAck && !ack_seen) cap = 1'b1;
        if (iTxDone) begin
          if (ack_seen || iMemAck) begin
            tx_load = 1'b1;
            data_n  = wr_q ? data_q : (ack_seen ? rdata_q : iMemRData);
            state_n = TX;
          end else begin
            state_n = MEM;
          end
        end
`else
        state_n = IDLE;
`endif
      end
      TX: begin
        if (iTxDone) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      retry_cnt <= '0;
      tx_msg    <= '0;
      transmit  <= 1'b0;
      dropped   <= 1'b0;
    end else begin
      transmit <= tx_load;
      dropped  <= drop;
      if (load) begin
        rd_q   <= iRead;
        wr_q   <= iWrite;
        err_q  <= iError;
        addr_q <= iAddr;
        data_q <= iData;
      end
      if (inc_retry)      retry_cnt <= retry_cnt + 4'd1;
      else if (clr_retry) retry_cnt <= '0;
      if (tx_load) tx_msg <= msg_n;
    end
  end

`ifdef MC_WAIT_MSG_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt <= '0;
      wait_sent <= 1'b0;
      ack_seen  <= 1'b0;
      rdata_q   <= '0;
    end else if (load) begin
      stall_cnt <= '0;
      wait_sent <= 1'b0;
      ack_seen  <= 1'b0;
    end else begin
      if (stall_inc) stall_cnt <= stall_cnt + 16'd1;
      if (wait_set)  wait_sent <= 1'b1;
      if (cap) begin
        ack_seen <= 1'b1;
        rdata_q  <= iMemRData;
      end
    end
  end

  assign oMemReq = (state == MEM) | ((state == TX_WAIT) & ~ack_seen);
`else
  assign oMemReq = (state == MEM);
`endif

  assign oBusy     = (state != IDLE);
  assign oMemWe    = oMemReq & wr_q;
  assign oMemAddr  = addr_q;
  assign oMemWData = data_q;
  assign oTransmit = transmit;
  assign oTxMsg    = tx_msg;
  assign oDropped  = dropped;

endmodule

// File: tb/tb_mc_txn_scheduler.sv
// Directed bench for mc_txn_scheduler with a transaction-level response model.
// WAIT-frame scenarios run only when MC_WAIT_MSG_EN is defined.
module tb_mc_txn_scheduler;

  localparam int MAX_RETRY   = 3;
  localparam int WAIT_CYCLES = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        iReqValid = 1'b0;
  logic        iRead = 1'b0;
  logic        iWrite = 1'b0;
  logic [23:0] iAddr = '0;
  logic [31:0] iData = '0;
  logic        iError = 1'b0;
  logic        oBusy;
  logic        oMemReq;
  logic        oMemWe;
  logic [23:0] oMemAddr;
  logic [31:0] oMemWData;
  logic        iMemAck = 1'b0;
  logic [31:0] iMemRData = '0;
  logic        oTransmit;
  logic [95:0] oTxMsg;
  logic        iTxDone = 1'b0;
  logic        oDropped;

  always #5 clk = ~clk;

  mc_txn_scheduler #(
    .MAX_RETRY(MAX_RETRY)
`ifdef MC_WAIT_MSG_EN
    ,
    .WAIT_CYCLES(WAIT_CYCLES)
`endif
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .iReqValid (iReqValid),
    .iRead     (iRead),
    .iWrite    (iWrite),
    .iAddr     (iAddr),
    .iData     (iData),
    .iError    (iError),
    .oBusy     (oBusy),
    .oMemReq   (oMemReq),
    .oMemWe    (oMemWe),
    .oMemAddr  (oMemAddr),
    .oMemWData (oMemWData),
    .iMemAck   (iMemAck),
    .iMemRData (iMemRData),
    .oTransmit (oTransmit),
    .oTxMsg    (oTxMsg),
    .iTxDone   (iTxDone),
    .oDropped  (oDropped)
  );

  int checks = 0;
  int fails = 0;

  logic [95:0] exp_q[$];
  int          drops_exp = 0;
  int          retries = 0;
  logic [23:0] m_addr = '0;
  logic [31:0] m_data = '0;
  logic        m_we = 1'b0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [95:0] frame(input logic [15:0] h, input logic [31:0] d,
                                        input logic [23:0] a);
    logic [7:0] e;
    e = (h == 16'hFFF3) ? 8'hFF : 8'h00;
    return {8'h0F, h, d, a, e, 8'hF0};
  endfunction

  // kind: 0 served, 1 retransmit, 2 dropped
  task automatic model_req(input logic rd, input logic wr, input logic err,
                           input logic [23:0] a, input logic [31:0] d,
                           input logic [31:0] rdata, input bit with_wait,
                           output int kind);
    if (err || rd == wr) begin
      if (retries < MAX_RETRY) begin
        retries++;
        exp_q.push_back(frame(16'hFFF3, 32'h0, a));
        kind = 1;
      end else begin
        retries = 0;
        drops_exp++;
        kind = 2;
      end
    end else begin
      retries = 0;
      m_addr = a;
      m_data = d;
      m_we = wr;
      if (with_wait) exp_q.push_back(frame(16'hFFF1, 32'h0, a));
      exp_q.push_back(frame(16'hFFF2, wr ? d : rdata, a));
      kind = 0;
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (oTransmit) begin
        check("tx_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("tx_msg", oTxMsg, exp_q.pop_front());
      end
      if (oDropped) begin
        check("drop_pending", drops_exp > 0, 1);
        if (drops_exp > 0) drops_exp--;
      end
      if (oMemReq) begin
        check("mem_addr", oMemAddr, m_addr);
        check("mem_we", oMemWe, m_we);
        if (m_we) check("mem_wdata", oMemWData, m_data);
      end
      if (!oBusy) check("idle_quiet", {oMemReq, oTransmit}, 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic rd, input logic wr, input logic err,
                      input logic [23:0] a, input logic [31:0] d,
                      input logic [31:0] rdata, input bit with_wait);
    int kind;
    model_req(rd, wr, err, a, d, rdata, with_wait, kind);
    iReqValid = 1'b1;
    iRead = rd;
    iWrite = wr;
    iError = err;
    iAddr = a;
    iData = d;
    tick();
    iReqValid = 1'b0;
    check("busy_after_req", oBusy, 1);
    check("no_memreq_in_check", oMemReq, 0);
    tick();
    if (kind == 0) begin
      check("memreq_after_check", oMemReq, 1);
    end else if (kind == 1) begin
      check("retx_pulse", oTransmit, 1);
      check("retx_no_memreq", oMemReq, 0);
    end else begin
      check("drop_pulse", oDropped, 1);
      check("drop_no_tx", oTransmit, 0);
      check("drop_idle", oBusy, 0);
      tick();
      check("drop_single", oDropped, 0);
    end
  endtask

  task automatic mem_ack(input int d, input logic [31:0] rdata);
    for (int j = 1; j < d; j++) tick();
    iMemAck = 1'b1;
    iMemRData = rdata;
    tick();
    iMemAck = 1'b0;
    iMemRData = 32'h5A5A5A5A;
    check("memreq_drop_after_ack", oMemReq, 0);
    check("tx_after_ack", oTransmit, 1);
  endtask

  task automatic tx_done(input logic [95:0] m);
    tick();
    check("tx_single_pulse", oTransmit, 0);
    check("tx_msg_held", oTxMsg, m);
    iTxDone = 1'b1;
    tick();
    iTxDone = 1'b0;
    check("idle_after_done", oBusy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [95:0] m;

    reset = 1'b0;
    tick();
    tick();
    check("rst_busy", oBusy, 0);
    check("rst_memreq", oMemReq, 0);
    check("rst_tx", oTransmit, 0);
    check("rst_drop", oDropped, 0);
    check("rst_msg", oTxMsg, 0);
    reset = 1'b1;
    tick();

    // write served after a two-cycle memory latency
    send(0, 1, 0, 24'h00000F, 32'hF0F0F0F0, 32'h12345678, 0);
    check("wr_memwe", oMemWe, 1);
    mem_ack(2, 32'h12345678);
    m = 96'h0F_FFF2_F0F0F0F0_00000F_00_F0;
    check("wr_ready_msg", oTxMsg, m);
    tx_done(m);

    // errored read, then a clean resend
    send(1, 0, 1, 24'hFFFFFF, 32'h0, 32'h0, 0);
    m = 96'h0F_FFF3_00000000_FFFFFF_FF_F0;
    check("retx_msg", oTxMsg, m);
    tx_done(m);
    send(1, 0, 0, 24'hFFFFFF, 32'h0, 32'hABCDEFAB, 0);
    check("rd_memwe", oMemWe, 0);
    mem_ack(1, 32'hABCDEFAB);
    m = 96'h0F_FFF2_ABCDEFAB_FFFFFF_00_F0;
    check("rd_ready_msg", oTxMsg, m);
    tx_done(m);

    // both opcode flags set is malformed
    send(1, 1, 0, 24'h123456, 32'h0, 32'h0, 0);
    tx_done(frame(16'hFFF3, 32'h0, 24'h123456));
    send(0, 1, 0, 24'h000100, 32'hCAFEF00D, 32'h0, 0);
    mem_ack(3, 32'h0);
    tx_done(frame(16'hFFF2, 32'hCAFEF00D, 24'h000100));

    // retry limit: three retransmits, then a drop
    for (int i = 0; i < 4; i++) begin
      send(1, 0, 1, 24'h000100 + 24'(i), 32'h0, 32'h0, 0);
      if (i < 3) tx_done(frame(16'hFFF3, 32'h0, 24'h000100 + 24'(i)));
    end
    send(1, 0, 0, 24'h000200, 32'h0, 32'h87654321, 0);
    mem_ack(3, 32'h87654321);
    tx_done(96'h0F_FFF2_87654321_000200_00_F0);

    // reset in the middle of a memory access
    send(0, 1, 0, 24'h345678, 32'hDEADBEEF, 32'h0, 0);
    tick();
    void'(exp_q.pop_back());
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("midrst_memreq", oMemReq, 0);
    check("midrst_busy", oBusy, 0);
    check("midrst_msg", oTxMsg, 0);
    iMemAck = 1'b1;
    iMemRData = 32'h11111111;
    tick();
    iMemAck = 1'b0;
    check("stray_ack_no_tx", oTransmit, 0);
    check("stray_ack_idle", oBusy, 0);
    send(1, 0, 0, 24'h345678, 32'h0, 32'h24681357, 0);
    mem_ack(2, 32'h24681357);
    tx_done(96'h0F_FFF2_24681357_345678_00_F0);

    // requests while busy are ignored
    send(1, 0, 0, 24'h0ABCDE, 32'h0, 32'h55AA55AA, 0);
    iReqValid = 1'b1;
    iRead = 1'b0;
    iWrite = 1'b1;
    iAddr = 24'h111111;
    iData = 32'h99999999;
    tick();
    iReqValid = 1'b0;
    mem_ack(1, 32'h55AA55AA);
    iReqValid = 1'b1;
    tick();
    iReqValid = 1'b0;
    m = 96'h0F_FFF2_55AA55AA_0ABCDE_00_F0;
    check("busy_req_msg", oTxMsg, m);
    tx_done(m);

    // iTxDone together with iReqValid drops the request
    send(0, 1, 0, 24'h00ABCD, 32'h01020304, 32'h0, 0);
    mem_ack(2, 32'h0);
    tick();
    iTxDone = 1'b1;
    iReqValid = 1'b1;
    iRead = 1'b1;
    iWrite = 1'b0;
    iError = 1'b0;
    tick();
    iTxDone = 1'b0;
    iReqValid = 1'b0;
    check("coincide_idle", oBusy, 0);
    tick();
    check("coincide_still_idle", oBusy, 0);
    check("coincide_no_memreq", oMemReq, 0);

`ifdef MC_WAIT_MSG_EN
    // long stall: WAIT frame, ack captured during it, then READY
    send(1, 0, 0, 24'h00C0DE, 32'h0, 32'h600DF00D, 1);
    for (int j = 1; j < WAIT_CYCLES; j++) tick();
    tick();
    check("wait_pulse", oTransmit, 1);
    check("wait_memreq_held", oMemReq, 1);
    check("wait_msg", oTxMsg, 96'h0F_FFF1_00000000_00C0DE_00_F0);
    for (int j = WAIT_CYCLES + 1; j < 12; j++) tick();
    iMemAck = 1'b1;
    iMemRData = 32'h600DF00D;
    tick();
    iMemAck = 1'b0;
    check("wait_ack_memreq", oMemReq, 0);
    check("wait_ack_busy", oBusy, 1);
    tick();
    iTxDone = 1'b1;
    tick();
    iTxDone = 1'b0;
    check("ready_after_wait", oTransmit, 1);
    m = 96'h0F_FFF2_600DF00D_00C0DE_00_F0;
    check("ready_after_wait_msg", oTxMsg, m);
    tx_done(m);

    // ack on the threshold cycle: no WAIT
    send(1, 0, 0, 24'h00BEEF, 32'h0, 32'h0BADCAFE, 0);
    mem_ack(WAIT_CYCLES, 32'h0BADCAFE);
    tx_done(96'h0F_FFF2_0BADCAFE_00BEEF_00_F0);
`endif

    tick();
    tick();
    check("all_tx_seen", exp_q.size(), 0);
    check("all_drops_seen", drops_exp, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
